ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: clk, rst_n.
REQ-002 clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-003 id_valid in 1; id_pc in 32; id_rs1_data, id_rs2_data, id_imm in 32 each; id_rs1, id_rs2, id_rd in 5 each; id_alu_select in 4; id_use_imm, id_reg_write, id_mem_read, id_mem_write in 1 each -- decoded ID-stage instruction.
REQ-004 stall in 1 (hold EX contents); flush in 1 (kill EX contents).
REQ-005 exmem_rd in 5, exmem_reg_write in 1, exmem_result in 32; memwb_rd in 5, memwb_reg_write in 1, memwb_result in 32 -- forwarding sources.
REQ-006 ex_valid out 1; alu_inp1, alu_inp2 out 32; alu_select out 4 -- ALU operands and opcode.
REQ-007 ex_pc, ex_store_data out 32; ex_rd out 5; ex_reg_write, ex_mem_read, ex_mem_write out 1 -- passed to EX/MEM.
REQ-008 load_use_hazard out 1, combinational -- ID must hold, EX receives a bubble.

Function
REQ-009 Latency SHALL be one cycle: ID fields captured at posedge clk appear on EX outputs after that edge.
REQ-010 Update priority per edge SHALL be flush > stall > load_use_hazard > capture.
REQ-011 flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write <= 0; alu_select <= 4'b0000; other fields don't-care.
REQ-012 stall (no flush): all control and ID fields held; rs1/rs2 operand registers reload their current forwarded values so writebacks retiring during the stall are not lost.
REQ-013 load_use_hazard (no flush/stall): bubble inserted, same as flush.
REQ-014 Otherwise: register all id_* fields; ex_valid <= id_valid; if id_valid=0, control bits <= 0.
REQ-015 load_use_hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); conservative, rs2 compared regardless of use.
REQ-016 Forwarded rs1: exmem match (exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1) -> exmem_result; else memwb match -> memwb_result; else registered rs1 data. rs2 identical.
REQ-017 Simultaneous EX/MEM and MEM/WB matches SHALL select EX/MEM (youngest wins).
REQ-018 Register x0 SHALL never be forwarded; rd=0 matches ignored.
REQ-019 alu_inp1 = forwarded rs1; alu_inp2 = id_imm register if use_imm else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-020 Outputs valid only when ex_valid=1; control bits SHALL be 0 whenever ex_valid=0.

Reset
REQ-021 rst_n low SHALL asynchronously clear every register: ex_valid, control bits, alu_select, rd, pc, operands, imm all 0.
REQ-022 Reset mid-stall or mid-hazard SHALL discard the EX instruction; first post-reset edge captures ID normally.
REQ-023 load_use_hazard SHALL be 0 in reset (ex_valid=0).

Configuration
REQ-024 Macro FORWARDING_EN defined: REQ-015..REQ-018 as stated.
REQ-025 FORWARDING_EN undefined: operands come from registered data only; load_use_hazard asserts on any id_rs1/id_rs2 match (rd!=0) against ex_rd with ex_reg_write&ex_valid, exmem_rd with exmem_reg_write, or memwb_rd with memwb_reg_write; exmem_*/memwb_* otherwise unused.

Verification
REQ-026 Reset: rst_n=0 async mid-cycle -> all outputs 0 immediately; release, id add x3,x1,x2 (12,15) -> next cycle alu_inp1=12, alu_inp2=15, alu_select=0, ex_valid=1.
REQ-027 Forward priority: ex_rs1=5, exmem_rd=5/result=100, memwb_rd=5/result=200 -> alu_inp1=100; drop exmem_reg_write -> 200; exmem_rd=0 -> registered value.
REQ-028 Load-use: EX lw x7 (mem_read=1), ID add x8,x7,x1 -> load_use_hazard=1; next edge ex_valid=0, ex_reg_write=0; ID hold -> add issues with x7 forwarded from memwb.
REQ-029 Stall refresh: stall=1 for 3 cycles, memwb writes ex_rs2 on cycle 2 with 0xDEAD -> after stall release ex_store_data=0xDEAD; flush with stall together -> bubble.
REQ-030 Immediate: id_use_imm=1, imm=0xFFFFFFF0, rs2_data=7 -> alu_inp2=0xFFFFFFF0, ex_store_data=7; rerun REQ-027/028 without FORWARDING_EN -> hazards asserted, no forwarding.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID->EX operand stage bus: decoded instruction, pipeline control,
// forwarding sources and the EX-side operand/control outputs.
interface ex_operand_stage_if;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [3:0]  id_alu_select;
   logic        id_use_imm;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;

   logic        stall;
   logic        flush;

   logic [4:0]  exmem_rd;
   logic        exmem_reg_write;
   logic [31:0] exmem_result;
   logic [4:0]  memwb_rd;
   logic        memwb_reg_write;
   logic [31:0] memwb_result;

   logic        ex_valid;
   logic [31:0] alu_inp1;
   logic [31:0] alu_inp2;
   logic [3:0]  alu_select;
   logic [31:0] ex_pc;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        load_use_hazard;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_select, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
             stall, flush,
             exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write, memwb_result,
      input  ex_valid, alu_inp1, alu_inp2, alu_select, ex_pc, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_select, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
             stall, flush,
             exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write, memwb_result,
      output ex_valid, alu_inp1, alu_inp2, alu_select, ex_pc, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
   );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection.
// Define FORWARDING_EN for EX/MEM and MEM/WB bypassing; otherwise dependencies stall via load_use_hazard.
module ex_operand_stage (
   input  logic                 clk,
   input  logic                 rst_n,
   ex_operand_stage_if.slave    bus
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_select;
      logic        use_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } ex_reg_t;

   ex_reg_t     ex_q, ex_d;
   logic [31:0] fwd_rs1;
   logic [31:0] fwd_rs2;
   logic        hazard;

`ifdef FORWARDING_EN
   logic exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;

   // EX/MEM is checked first so the youngest producer wins; rd=0 never matches.
   always_comb begin
      exmem_hit1 = bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_q.rs1);
      exmem_hit2 = bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_q.rs2);
      memwb_hit1 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_q.rs1);
      memwb_hit2 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_q.rs2);
      fwd_rs1 = exmem_hit1 ? bus.exmem_result : (memwb_hit1 ? bus.memwb_result : ex_q.rs1_data);
      fwd_rs2 = exmem_hit2 ? bus.exmem_result : (memwb_hit2 ? bus.memwb_result : ex_q.rs2_data);
      hazard  = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
   end
`else
   logic ex_dep, exmem_dep, memwb_dep;
   logic unused_nofwd;

   // Without bypassing, any in-flight writer of an ID source holds ID until it retires.
   always_comb begin
      fwd_rs1   = ex_q.rs1_data;
      fwd_rs2   = ex_q.rs2_data;
      ex_dep    = ex_q.valid && ex_q.reg_write && (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
      exmem_dep = bus.exmem_reg_write && (bus.exmem_rd != 5'd0) &&
                  ((bus.exmem_rd == bus.id_rs1) || (bus.exmem_rd == bus.id_rs2));
      memwb_dep = bus.memwb_reg_write && (bus.memwb_rd != 5'd0) &&
                  ((bus.memwb_rd == bus.id_rs1) || (bus.memwb_rd == bus.id_rs2));
      hazard    = bus.id_valid && (ex_dep || exmem_dep || memwb_dep);
   end

   assign unused_nofwd = ^{ex_q.rs1, ex_q.rs2, bus.exmem_result, bus.memwb_result};
`endif

   always_comb begin
      ex_d = ex_q;
      if (bus.flush || (!bus.stall && hazard)) begin
         ex_d.valid      = 1'b0;
         ex_d.reg_write  = 1'b0;
         ex_d.mem_read   = 1'b0;
         ex_d.mem_write  = 1'b0;
         ex_d.alu_select = 4'b0000;
      end else if (bus.stall) begin
         // Reload operands so a writeback retiring during the stall is not lost.
         ex_d.rs1_data = fwd_rs1;
         ex_d.rs2_data = fwd_rs2;
      end else begin
         ex_d.valid      = bus.id_valid;
         ex_d.pc         = bus.id_pc;
         ex_d.rs1_data   = bus.id_rs1_data;
         ex_d.rs2_data   = bus.id_rs2_data;
         ex_d.imm        = bus.id_imm;
         ex_d.rs1        = bus.id_rs1;
         ex_d.rs2        = bus.id_rs2;
         ex_d.rd         = bus.id_rd;
         ex_d.alu_select = bus.id_alu_select;
         ex_d.use_imm    = bus.id_use_imm;
         ex_d.reg_write  = bus.id_valid && bus.id_reg_write;
         ex_d.mem_read   = bus.id_valid && bus.id_mem_read;
         ex_d.mem_write  = bus.id_valid && bus.id_mem_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign bus.ex_valid        = ex_q.valid;
   assign bus.alu_inp1        = fwd_rs1;
   assign bus.alu_inp2        = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign bus.alu_select      = ex_q.alu_select;
   assign bus.ex_pc           = ex_q.pc;
   assign bus.ex_store_data   = fwd_rs2;
   assign bus.ex_rd           = ex_q.rd;
   assign bus.ex_reg_write    = ex_q.reg_write;
   assign bus.ex_mem_read     = ex_q.mem_read;
   assign bus.ex_mem_write    = ex_q.mem_write;
   assign bus.load_use_hazard = hazard && rst_n;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed checks of ex_operand_stage in the build selected by FORWARDING_EN.
module tb_ex_operand_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ex_operand_stage_if bus ();

   ex_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [4:0] rd, input logic [31:0] imm,
                           input logic [3:0] sel, input logic ui,
                           input logic rw, input logic mr, input logic mw);
      bus.id_valid = v; bus.id_pc = pc;
      bus.id_rs1 = rs1; bus.id_rs1_data = d1;
      bus.id_rs2 = rs2; bus.id_rs2_data = d2;
      bus.id_rd = rd; bus.id_imm = imm; bus.id_alu_select = sel; bus.id_use_imm = ui;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
   endtask

   task automatic clear_fwd;
      bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b0; bus.exmem_result = 32'd0;
      bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b0; bus.memwb_result = 32'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
      clear_fwd();
      drive_id(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      drive_id(1'b1, 32'h80, 5'd4, 32'h44, 5'd9, 32'h99, 5'd6, 32'd0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", bus.ex_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", bus.ex_valid); end
      checks++; if (bus.alu_inp1 !== 32'd0 || bus.alu_inp2 !== 32'd0 || bus.ex_store_data !== 32'd0) begin
         failures++; $display("FAIL async_rst_operands got=%h/%h/%h exp=0", bus.alu_inp1, bus.alu_inp2, bus.ex_store_data); end
      checks++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.alu_select, bus.ex_rd} !== 12'd0 || bus.ex_pc !== 32'd0) begin
         failures++; $display("FAIL async_rst_ctrl got=%b pc=%h exp=0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.alu_select, bus.ex_rd}, bus.ex_pc); end
      checks++; if (bus.load_use_hazard !== 1'b0) begin failures++; $display("FAIL async_rst_hazard got=%b exp=0", bus.load_use_hazard); end
      #2 rst_n = 1'b1;
      drive_id(1'b1, 32'h100, 5'd1, 32'd12, 5'd2, 32'd15, 5'd3, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (bus.alu_inp1 !== 32'd12) begin failures++; $display("FAIL rst_add_inp1 got=%h exp=%h", bus.alu_inp1, 32'd12); end
      checks++; if (bus.alu_inp2 !== 32'd15) begin failures++; $display("FAIL rst_add_inp2 got=%h exp=%h", bus.alu_inp2, 32'd15); end
      checks++; if (bus.alu_select !== 4'h0 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1) begin
         failures++; $display("FAIL rst_add_ctrl got=sel%h v%b rd%0d rw%b exp=sel0 v1 rd3 rw1", bus.alu_select, bus.ex_valid, bus.ex_rd, bus.ex_reg_write); end
   endtask

   task automatic test_forward_priority;
      clear_fwd();
      drive_id(1'b1, 32'h110, 5'd5, 32'd55, 5'd6, 32'd66, 5'd20, 32'd0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'd100;
      bus.memwb_rd = 5'd5; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'd200;
      #1;
`ifdef FORWARDING_EN
      checks++; if (bus.alu_inp1 !== 32'd100) begin failures++; $display("FAIL fwd_both_exmem got=%0d exp=100", bus.alu_inp1); end
      checks++; if (bus.load_use_hazard !== 1'b0) begin failures++; $display("FAIL fwd_no_hazard got=%b exp=0", bus.load_use_hazard); end
      bus.exmem_reg_write = 1'b0; #1;
      checks++; if (bus.alu_inp1 !== 32'd200) begin failures++; $display("FAIL fwd_memwb got=%0d exp=200", bus.alu_inp1); end
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; #1;
      checks++; if (bus.alu_inp1 !== 32'd200) begin failures++; $display("FAIL fwd_exmem_x0 got=%0d exp=200", bus.alu_inp1); end
      bus.memwb_rd = 5'd0; #1;
      checks++; if (bus.alu_inp1 !== 32'd55) begin failures++; $display("FAIL fwd_none got=%0d exp=55", bus.alu_inp1); end
      bus.memwb_rd = 5'd6; #1;
      checks++; if (bus.ex_store_data !== 32'd200 || bus.alu_inp2 !== 32'd200) begin
         failures++; $display("FAIL fwd_rs2_memwb got=%0d/%0d exp=200", bus.ex_store_data, bus.alu_inp2); end
`else
      checks++; if (bus.alu_inp1 !== 32'd55) begin failures++; $display("FAIL nofwd_inp1 got=%0d exp=55", bus.alu_inp1); end
      checks++; if (bus.load_use_hazard !== 1'b1) begin failures++; $display("FAIL nofwd_hazard_both got=%b exp=1", bus.load_use_hazard); end
      bus.exmem_reg_write = 1'b0; #1;
      checks++; if (bus.load_use_hazard !== 1'b1) begin failures++; $display("FAIL nofwd_hazard_memwb got=%b exp=1", bus.load_use_hazard); end
      checks++; if (bus.alu_inp1 !== 32'd55) begin failures++; $display("FAIL nofwd_inp1_memwb got=%0d exp=55", bus.alu_inp1); end
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0; #1;
      checks++; if (bus.load_use_hazard !== 1'b0) begin failures++; $display("FAIL nofwd_hazard_x0 got=%b exp=0", bus.load_use_hazard); end
      bus.memwb_rd = 5'd6; #1;
      checks++; if (bus.load_use_hazard !== 1'b1 || bus.ex_store_data !== 32'd66) begin
         failures++; $display("FAIL nofwd_rs2 got=hz%b data%0d exp=hz1 data66", bus.load_use_hazard, bus.ex_store_data); end
`endif
      clear_fwd();
   endtask

   task automatic test_load_use;
      clear_fwd();
      drive_id(1'b1, 32'h200, 5'd2, 32'd1000, 5'd0, 32'd0, 5'd7, 32'd4, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(1'b1, 32'h204, 5'd7, 32'd0, 5'd1, 32'd3, 5'd8, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (bus.load_use_hazard !== 1'b1) begin failures++; $display("FAIL lu_hazard got=%b exp=1", bus.load_use_hazard); end
      tick();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
         failures++; $display("FAIL lu_bubble got=v%b rw%b mr%b exp=0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read); end
      bus.exmem_rd = 5'd7; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h77;
      #1;
`ifdef FORWARDING_EN
      checks++; if (bus.load_use_hazard !== 1'b0) begin failures++; $display("FAIL lu_hazard_clear got=%b exp=0", bus.load_use_hazard); end
      tick();
      clear_fwd();
      bus.memwb_rd = 5'd7; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h77;
      #1;
`else
      checks++; if (bus.load_use_hazard !== 1'b1) begin failures++; $display("FAIL lu_hazard_exmem got=%b exp=1", bus.load_use_hazard); end
      tick();
      clear_fwd();
      bus.memwb_rd = 5'd7; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h77;
      #1;
      checks++; if (bus.load_use_hazard !== 1'b1) begin failures++; $display("FAIL lu_hazard_memwb got=%b exp=1", bus.load_use_hazard); end
      tick();
      clear_fwd();
      bus.id_rs1_data = 32'h77;
      #1;
      checks++; if (bus.load_use_hazard !== 1'b0) begin failures++; $display("FAIL lu_hazard_retired got=%b exp=0", bus.load_use_hazard); end
      tick();
`endif
      checks++; if (bus.alu_inp1 !== 32'h77 || bus.alu_inp2 !== 32'd3) begin
         failures++; $display("FAIL lu_issue_ops got=%h/%h exp=77/3", bus.alu_inp1, bus.alu_inp2); end
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_pc !== 32'h204) begin
         failures++; $display("FAIL lu_issue_ctrl got=v%b rd%0d pc%h exp=v1 rd8 pc204", bus.ex_valid, bus.ex_rd, bus.ex_pc); end
      clear_fwd();
   endtask

   task automatic test_stall_refresh;
      clear_fwd();
      drive_id(1'b1, 32'h300, 5'd9, 32'h11, 5'd10, 32'h22, 5'd11, 32'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      bus.stall = 1'b1;
      drive_id(1'b1, 32'h304, 5'd12, 32'h333, 5'd13, 32'h999, 5'd14, 32'd0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.memwb_rd = 5'd10; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hDEAD;
      tick();
      clear_fwd();
      tick();
      bus.stall = 1'b0;
      #1;
`ifdef FORWARDING_EN
      checks++; if (bus.ex_store_data !== 32'hDEAD) begin failures++; $display("FAIL stall_refresh got=%h exp=0000dead", bus.ex_store_data); end
`else
      checks++; if (bus.ex_store_data !== 32'h22) begin failures++; $display("FAIL stall_hold_data got=%h exp=00000022", bus.ex_store_data); end
`endif
      checks++; if (bus.ex_pc !== 32'h300 || bus.ex_rd !== 5'd11 || bus.alu_select !== 4'h2 || bus.alu_inp1 !== 32'h11) begin
         failures++; $display("FAIL stall_hold got=pc%h rd%0d sel%h in1%h exp=pc300 rd11 sel2 in1 11", bus.ex_pc, bus.ex_rd, bus.alu_select, bus.alu_inp1); end
      checks++; if (bus.ex_mem_write !== 1'b1 || bus.ex_valid !== 1'b1) begin
         failures++; $display("FAIL stall_hold_ctrl got=mw%b v%b exp=1/1", bus.ex_mem_write, bus.ex_valid); end
      bus.stall = 1'b1; bus.flush = 1'b1;
      tick();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.alu_select !== 4'h0) begin
         failures++; $display("FAIL flush_stall got=v%b rw%b mw%b sel%h exp=0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write, bus.alu_select); end
      bus.stall = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic test_immediate;
      clear_fwd();
      drive_id(1'b1, 32'h400, 5'd3, 32'd9, 5'd12, 32'd7, 5'd15, 32'hFFFF_FFF0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (bus.alu_inp2 !== 32'hFFFF_FFF0) begin failures++; $display("FAIL imm_inp2 got=%h exp=fffffff0", bus.alu_inp2); end
      checks++; if (bus.ex_store_data !== 32'd7 || bus.alu_select !== 4'h1) begin
         failures++; $display("FAIL imm_store got=%h sel%h exp=7 sel1", bus.ex_store_data, bus.alu_select); end
   endtask

   task automatic test_invalid_capture;
      drive_id(1'b0, 32'h500, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 4'b0000) begin
         failures++; $display("FAIL invalid_ctrl got=%b exp=0000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}); end
   endtask

   task automatic test_back_to_back;
      clear_fwd();
      drive_id(1'b1, 32'h600, 5'd1, 32'hA1, 5'd2, 32'hB2, 5'd16, 32'd0, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (bus.ex_pc !== 32'h600 || bus.alu_select !== 4'h7 || bus.alu_inp1 !== 32'hA1) begin
         failures++; $display("FAIL b2b_first got=pc%h sel%h in1%h exp=pc600 sel7 in1 a1", bus.ex_pc, bus.alu_select, bus.alu_inp1); end
      drive_id(1'b1, 32'h604, 5'd3, 32'hC3, 5'd4, 32'hD4, 5'd17, 32'd0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (bus.ex_pc !== 32'h604 || bus.alu_select !== 4'h8 || bus.alu_inp2 !== 32'hD4 || bus.ex_rd !== 5'd17) begin
         failures++; $display("FAIL b2b_second got=pc%h sel%h in2%h rd%0d exp=pc604 sel8 in2 d4 rd17", bus.ex_pc, bus.alu_select, bus.alu_inp2, bus.ex_rd); end
   endtask

   task automatic test_reset_mid_stall;
      bus.stall = 1'b1;
      drive_id(1'b1, 32'h700, 5'd1, 32'h5, 5'd2, 32'h6, 5'd18, 32'd0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (bus.ex_pc !== 32'h604) begin failures++; $display("FAIL mid_stall_hold got=%h exp=00000604", bus.ex_pc); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
         failures++; $display("FAIL mid_stall_rst got=v%b rw%b exp=0", bus.ex_valid, bus.ex_reg_write); end
      bus.stall = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h700 || bus.alu_select !== 4'h9) begin
         failures++; $display("FAIL post_rst_capture got=v%b pc%h sel%h exp=v1 pc700 sel9", bus.ex_valid, bus.ex_pc, bus.alu_select); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_forward_priority();
      test_load_use();
      test_stall_refresh();
      test_immediate();
      test_invalid_capture();
      test_back_to_back();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
